// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline controller
// Contents: data-memory state encoding, stage bit positions in the enable
// vector, counter widths used by the controller and its memory FSM.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_RD   = 2'd0,
        MEM_IND  = 2'd1,
        MEM_WR   = 2'd2,
        MEM_IDLE = 2'd3
    } mem_state_t;

    localparam int STG_UPDPC  = 0;
    localparam int STG_FETCH  = 1;
    localparam int STG_DECODE = 2;
    localparam int STG_EXEC   = 3;
    localparam int STG_WB     = 4;

    // Wide enough for MEM_WAIT_MAX up to 255 and FLUSH_CYCLES up to 7.
    localparam int WAIT_CW  = 8;
    localparam int FLUSH_CW = 3;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// rtl/pipe_ctrl_unit_if.sv - datapath status / control_out bus of the pipeline controller
// master: datapath side, drives status (src_*, ex_*, wb_*, mem_req/write/indirect/ack, br_req)
//         and observes control (enable, br_taken, bypass_*, mem_state, mem_timeout).
// slave:  controller side, the reverse directions.
interface pipe_ctrl_unit_if #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_SRC    = 2,
    parameter int REG_AW     = 3
);
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*REG_AW-1:0] src_addr;
    logic                      ex_wr_en;
    logic [REG_AW-1:0]         ex_dst;
    logic                      ex_is_load;
    logic                      wb_wr_en;
    logic [REG_AW-1:0]         wb_dst;
    logic                      mem_req;
    logic                      mem_write;
    logic                      mem_indirect;
    logic                      mem_ack;
    logic                      br_req;

    logic [NUM_STAGES-1:0]     enable;
    logic                      br_taken;
    logic [NUM_SRC-1:0]        bypass_alu;
    logic [NUM_SRC-1:0]        bypass_mem;
    logic [1:0]                mem_state;
    logic                      mem_timeout;

    modport master (
        output src_valid, src_addr, ex_wr_en, ex_dst, ex_is_load, wb_wr_en, wb_dst,
               mem_req, mem_write, mem_indirect, mem_ack, br_req,
        input  enable, br_taken, bypass_alu, bypass_mem, mem_state, mem_timeout
    );

    modport slave (
        input  src_valid, src_addr, ex_wr_en, ex_dst, ex_is_load, wb_wr_en, wb_dst,
               mem_req, mem_write, mem_indirect, mem_ack, br_req,
        output enable, br_taken, bypass_alu, bypass_mem, mem_state, mem_timeout
    );
endinterface

// File: rtl/pipe_ctrl_mem_fsm.sv
// rtl/pipe_ctrl_mem_fsm.sv - data-memory access FSM with wait counter and sticky timeout
// Ports: clock, reset (async active-low), issue (accepted mem_req from idle),
//        mem_indirect/mem_write (op kind), mem_ack (access done),
//        mem_state (registered state), mem_timeout (sticky until reset).
module pipe_ctrl_mem_fsm
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       issue,
    input  logic       mem_indirect,
    input  logic       mem_write,
    input  logic       mem_ack,
    output mem_state_t mem_state,
    output logic       mem_timeout
);

    localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(MEM_WAIT_MAX - 1);

    logic [WAIT_CW-1:0] wait_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_state   <= MEM_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            case (mem_state)
                MEM_IDLE: begin
                    if (issue) begin
                        wait_cnt <= '0;
                        if (mem_indirect)   mem_state <= MEM_IND;
                        else if (mem_write) mem_state <= MEM_WR;
                        else                mem_state <= MEM_RD;
                    end
                end
                default: begin
                    // Ack is tested before the limit so a late ack is never a timeout.
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (mem_state == MEM_IND) mem_state <= mem_write ? MEM_WR : MEM_RD;
                        else                      mem_state <= MEM_IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wait_cnt    <= '0;
                        mem_state   <= MEM_IDLE;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipeline controller: stage enables, branch flush, bypass selects
// Ports: clock, reset (async active-low), bus (pipe_ctrl_unit_if.slave carrying
//        datapath status in and enable/br_taken/bypass_*/mem_state/mem_timeout out).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES   = 5,
    parameter int NUM_SRC      = 2,
    parameter int REG_AW       = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic              clock,
    input  logic              reset,
    pipe_ctrl_unit_if.slave   bus
);

    mem_state_t            mem_state;
    logic                  mem_timeout;
    logic [FLUSH_CW-1:0]   flush_cnt;
    logic                  br_taken;

    logic                  mem_busy;
    logic                  flush_active;
    logic                  load_use;
    logic                  br_accept;
    logic                  mem_issue;
    logic [NUM_SRC-1:0]    ex_hit;
    logic [NUM_SRC-1:0]    wb_hit;
    logic [NUM_SRC-1:0]    alu_sel;
    logic [NUM_SRC-1:0]    mem_sel;
    logic [NUM_STAGES-1:0] en;

    assign mem_busy     = (mem_state != MEM_IDLE);
    assign flush_active = (flush_cnt != '0);

    // Per-operand address matches against both producers.
    always_comb begin
        ex_hit = '0;
        wb_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ex_hit[i] = bus.src_valid[i] && (bus.src_addr[i*REG_AW +: REG_AW] == bus.ex_dst);
            wb_hit[i] = bus.src_valid[i] && (bus.src_addr[i*REG_AW +: REG_AW] == bus.wb_dst);
        end
    end

    assign load_use = bus.ex_is_load && bus.ex_wr_en && (|ex_hit);

    // Stages above writeback share its enable since they sit downstream of it.
    always_comb begin
        en = '1;
        if (mem_busy) begin
            en = '0;
        end else if (load_use) begin
            en[STG_EXEC:STG_UPDPC] = '0;
        end else if (flush_active) begin
            en[STG_DECODE] = 1'b0;
            en[STG_EXEC]   = 1'b0;
        end
    end

    // Execute result wins over writeback; a load in execute has no result yet.
    assign alu_sel = {NUM_SRC{bus.ex_wr_en && !bus.ex_is_load}} & ex_hit;
    assign mem_sel = {NUM_SRC{bus.wb_wr_en}} & wb_hit & ~alu_sel;

    // A branch arriving while a flush is already running restarts the window,
    // even though execute is bubbled; memory wait and load-use still block it.
    assign br_accept = bus.br_req &&
                       (en[STG_EXEC] || (flush_active && !mem_busy && !load_use));
    assign mem_issue = bus.mem_req && en[STG_EXEC];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flush_cnt <= '0;
            br_taken  <= 1'b0;
        end else begin
            br_taken <= br_accept;
            if (br_accept)         flush_cnt <= FLUSH_CW'(FLUSH_CYCLES);
            else if (flush_active) flush_cnt <= flush_cnt - 1'b1;
        end
    end

    pipe_ctrl_mem_fsm #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_fsm (
        .clock        (clock),
        .reset        (reset),
        .issue        (mem_issue),
        .mem_indirect (bus.mem_indirect),
        .mem_write    (bus.mem_write),
        .mem_ack      (bus.mem_ack),
        .mem_state    (mem_state),
        .mem_timeout  (mem_timeout)
    );

    assign bus.enable      = en;
    assign bus.br_taken    = br_taken;
    assign bus.bypass_alu  = (flush_active || mem_busy) ? '0 : alu_sel;
    assign bus.bypass_mem  = (flush_active || mem_busy) ? '0 : mem_sel;
    assign bus.mem_state   = mem_state;
    assign bus.mem_timeout = mem_timeout;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - scoreboard bench for pipe_ctrl_unit
module tb_pipe_ctrl_unit;

    typedef struct {
        string      lbl;
        logic [4:0] en;
        logic       bt;
        logic [1:0] ba;
        logic [1:0] bm;
        logic [1:0] ms;
        logic       to;
    } exp_t;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    pipe_ctrl_unit_if #(.NUM_STAGES(5), .NUM_SRC(2), .REG_AW(3)) bus ();

    pipe_ctrl_unit #(
        .NUM_STAGES   (5),
        .NUM_SRC      (2),
        .REG_AW       (3),
        .FLUSH_CYCLES (2),
        .MEM_WAIT_MAX (15)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string lbl, input logic [4:0] en, input logic bt,
                            input logic [1:0] ba, input logic [1:0] bm,
                            input logic [1:0] ms, input logic to);
        exp_t e;
        e.lbl = lbl; e.en = en; e.bt = bt; e.ba = ba; e.bm = bm; e.ms = ms; e.to = to;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.lbl, ".enable"},      32'(bus.enable),      32'(e.en));
            check({e.lbl, ".br_taken"},    32'(bus.br_taken),    32'(e.bt));
            check({e.lbl, ".bypass_alu"},  32'(bus.bypass_alu),  32'(e.ba));
            check({e.lbl, ".bypass_mem"},  32'(bus.bypass_mem),  32'(e.bm));
            check({e.lbl, ".mem_state"},   32'(bus.mem_state),   32'(e.ms));
            check({e.lbl, ".mem_timeout"}, 32'(bus.mem_timeout), 32'(e.to));
        end
    endtask

    // Inputs are set just after a rising edge; the expectation for that cycle is
    // queued, then compared on the falling edge, and we step to the next edge.
    task automatic cycle(input string lbl, input logic [4:0] en, input logic bt,
                         input logic [1:0] ba, input logic [1:0] bm,
                         input logic [1:0] ms, input logic to);
        push_exp(lbl, en, bt, ba, bm, ms, to);
        @(negedge clock);
        pop_compare();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.src_valid    = '0;
        bus.src_addr     = '0;
        bus.ex_wr_en     = 1'b0;
        bus.ex_dst       = '0;
        bus.ex_is_load   = 1'b0;
        bus.wb_wr_en     = 1'b0;
        bus.wb_dst       = '0;
        bus.mem_req      = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_indirect = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.br_req       = 1'b0;
    endtask

    localparam logic [4:0] ALL = 5'b11111;

    initial begin
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        push_exp("reset", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        pop_compare();
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Load-use hazard on operand 0.
        bus.ex_is_load = 1; bus.ex_wr_en = 1; bus.ex_dst = 3'd3;
        bus.src_valid = 2'b01; bus.src_addr = {3'd0, 3'd3};
        cycle("load_use", 5'b10000, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("after_lu", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Bypass selection.
        bus.ex_dst = 3'd2; bus.wb_dst = 3'd2; bus.src_addr = {3'd2, 3'd2};
        bus.src_valid = 2'b11; bus.ex_wr_en = 1; bus.wb_wr_en = 1;
        cycle("byp_alu", ALL, 0, 2'b11, 2'b00, 2'd3, 0);
        bus.ex_wr_en = 0;
        cycle("byp_mem", ALL, 0, 2'b00, 2'b11, 2'd3, 0);
        bus.src_addr = {3'd2, 3'd5};
        cycle("byp_mem_src1", ALL, 0, 2'b00, 2'b10, 2'd3, 0);
        bus.src_valid = 2'b01; bus.src_addr = {3'd2, 3'd2};
        cycle("byp_valid_gate", ALL, 0, 2'b00, 2'b01, 2'd3, 0);
        bus.ex_wr_en = 1; bus.ex_is_load = 1; bus.ex_dst = 3'd6;
        cycle("byp_load_in_ex", ALL, 0, 2'b00, 2'b01, 2'd3, 0);
        clear_inputs();

        // Indirect load, acks on busy cycles 3 and 6.
        bus.mem_req = 1; bus.mem_indirect = 1;
        cycle("ind_issue", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("ind_c1", 5'b00000, 0, 2'b00, 2'b00, 2'd1, 0);
        bus.src_valid = 2'b01; bus.src_addr = {3'd0, 3'd4};
        bus.ex_wr_en = 1; bus.ex_dst = 3'd4; bus.wb_wr_en = 1; bus.wb_dst = 3'd4;
        cycle("ind_c2_bypass_masked", 5'b00000, 0, 2'b00, 2'b00, 2'd1, 0);
        clear_inputs();
        bus.mem_ack = 1;
        cycle("ind_c3", 5'b00000, 0, 2'b00, 2'b00, 2'd1, 0);
        bus.mem_ack = 0;
        cycle("ind_c4", 5'b00000, 0, 2'b00, 2'b00, 2'd0, 0);
        cycle("ind_c5", 5'b00000, 0, 2'b00, 2'b00, 2'd0, 0);
        bus.mem_ack = 1;
        cycle("ind_c6", 5'b00000, 0, 2'b00, 2'b00, 2'd0, 0);
        clear_inputs();
        cycle("ind_done", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Taken branch and flush window, bypass masked during flush.
        bus.br_req = 1;
        cycle("br_req", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        bus.br_req = 0;
        bus.src_valid = 2'b01; bus.src_addr = {3'd0, 3'd1}; bus.ex_wr_en = 1; bus.ex_dst = 3'd1;
        cycle("br_pulse", 5'b10011, 1, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("br_flush2", 5'b10011, 0, 2'b00, 2'b00, 2'd3, 0);
        cycle("br_done", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Second branch during an active flush restarts the window.
        bus.br_req = 1;
        cycle("rl_req", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        cycle("rl_req2", 5'b10011, 1, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("rl_f1", 5'b10011, 1, 2'b00, 2'b00, 2'd3, 0);
        cycle("rl_f2", 5'b10011, 0, 2'b00, 2'b00, 2'd3, 0);
        cycle("rl_done", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Simultaneous memory read and branch.
        bus.mem_req = 1; bus.br_req = 1;
        cycle("sim_issue", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("sim_c1", 5'b00000, 1, 2'b00, 2'b00, 2'd0, 0);
        bus.mem_ack = 1;
        cycle("sim_c2", 5'b00000, 0, 2'b00, 2'b00, 2'd0, 0);
        clear_inputs();
        cycle("sim_done", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Store acked on the limit cycle: no timeout.
        bus.mem_req = 1; bus.mem_write = 1;
        cycle("lim_issue", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        for (int i = 1; i <= 14; i++)
            cycle($sformatf("lim_wait%0d", i), 5'b00000, 0, 2'b00, 2'b00, 2'd2, 0);
        bus.mem_ack = 1;
        cycle("lim_ack15", 5'b00000, 0, 2'b00, 2'b00, 2'd2, 0);
        clear_inputs();
        cycle("lim_done", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        // Store with no ack: timeout after 15 cycles, sticky.
        bus.mem_req = 1; bus.mem_write = 1;
        cycle("to_issue", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        for (int i = 1; i <= 15; i++)
            cycle($sformatf("to_wait%0d", i), 5'b00000, 0, 2'b00, 2'b00, 2'd2, 0);
        cycle("to_done", ALL, 0, 2'b00, 2'b00, 2'd3, 1);
        cycle("to_sticky", ALL, 0, 2'b00, 2'b00, 2'd3, 1);

        // Async reset in the middle of a read, with an ack pending.
        bus.mem_req = 1;
        cycle("rd_issue", ALL, 0, 2'b00, 2'b00, 2'd3, 1);
        clear_inputs();
        cycle("rd_c1", 5'b00000, 0, 2'b00, 2'b00, 2'd0, 1);
        #2;
        reset = 1'b0;
        bus.mem_ack = 1;
        #1;
        push_exp("async_reset", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        pop_compare();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        cycle("post_reset_ack", ALL, 0, 2'b00, 2'b00, 2'd3, 0);
        clear_inputs();
        cycle("post_reset_idle", ALL, 0, 2'b00, 2'b00, 2'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Parametrised pipeline controller that drives the control_out bus: stage enables, branch-taken pulse, operand bypass selects and the data-memory state.
- Sits between decode/execute/writeback datapath status and the stage registers.
- The previous generation had fixed single-bit bypasses and no memory-wait tracking.
- This block adds N-operand bypassing, a load-use stall, a branch flush window and a memory FSM with timeout.

Parameters:
NUM_STAGES, 5, width of enable vector; bit0 updatePC, 1 fetch, 2 decode, 3 execute, 4 writeback; bits >=5 follow bit4; minimum 5
NUM_SRC, 2, number of source operands checked for bypass
REG_AW, 3, register address width
FLUSH_CYCLES, 2, cycles decode/execute are held off after a taken branch (1..7)
MEM_WAIT_MAX, 15, maximum cycles waiting for mem_ack before timeout (1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
src_valid  in  NUM_SRC  decode operand i is used
src_addr  in  NUM_SRC*REG_AW  decode operand addresses, operand i at [i*REG_AW +: REG_AW]
ex_wr_en  in  1  execute stage writes a register
ex_dst  in  REG_AW  execute destination
ex_is_load  in  1  execute instruction is a load (result from memory)
wb_wr_en  in  1  memory/writeback stage writes a register
wb_dst  in  REG_AW  writeback destination
mem_req  in  1  execute issues a memory op
mem_write  in  1  op is a store
mem_indirect  in  1  op needs an address-fetch access first
mem_ack  in  1  data memory access complete
br_req  in  1  execute resolved a taken branch
enable  out  NUM_STAGES  stage enables
br_taken  out  1  one-cycle taken pulse
bypass_alu  out  NUM_SRC  operand i takes execute result
bypass_mem  out  NUM_SRC  operand i takes writeback result
mem_state  out  2  3 idle, 1 indirect, 0 read, 2 write
mem_timeout  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async):
  - enable = all 1s.
  - br_taken = 0; bypass_* = 0.
  - mem_state = 3; mem_timeout = 0; flush and wait counters = 0.
- mem_state is registered. br_taken, flush counter, wait counter and mem_timeout are registered. enable and bypass_* are combinational from the current registered state and inputs.
- Memory FSM, evaluated when mem_state=3 and enable[3]=1:
  - mem_req=1: next state 1 if mem_indirect, else 2 if mem_write, else 0.
  - The wait counter clears on every state entry.
- In states 0/1/2:
  - mem_ack=1: 1 goes to 0 (or 2 if mem_write); 0 and 2 go to 3.
  - No ack: counter increments; when it reaches MEM_WAIT_MAX the state goes to 3 and mem_timeout sets. mem_timeout stays set until reset.
  - An ack on the same cycle as the limit wins; no timeout is raised.
- Priority of enable generation, highest first:
  1. Memory busy (mem_state!=3): enable = 0. Registers hold.
  2. Load-use: ex_is_load & ex_wr_en & any i(src_valid[i] & src_addr_i==ex_dst). enable[2:0]=0, enable[3]=0 (bubble), enable[4]=1.
  3. Flush (flush counter !=0): enable[2]=0, enable[3]=0, others 1. Counter decrements each cycle.
  4. Otherwise enable = all 1s.
- Branch:
  - When br_req=1 and enable[3]=1: br_taken=1 on the next cycle for exactly one cycle, and the flush counter loads FLUSH_CYCLES.
  - br_req while enable[3]=0 is ignored; upstream holds it.
  - br_req during an active flush reloads the counter.
- Bypass for each i, gated by src_valid[i]:
  - bypass_alu[i] = ex_wr_en & !ex_is_load & src_addr_i==ex_dst.
  - bypass_mem[i] = wb_wr_en & src_addr_i==wb_dst & !bypass_alu[i]. The youngest producer wins.
  - All bypass bits are 0 while the flush counter !=0 or mem_state!=3.
- Simultaneous mem_req and br_req with enable[3]=1: both are accepted. The FSM leaves idle and the flush counter loads; memory-busy priority masks flush enables, but the counter still decrements.
- Reset mid-access: FSM returns to 3 immediately; any pending ack is ignored.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef mem_state_t: MEM_RD=0, MEM_IND=1, MEM_WR=2, MEM_IDLE=3.
  - Stage index constants: STG_UPDPC, STG_FETCH, STG_DECODE, STG_EXEC, STG_WB.
- Sub-module pipe_ctrl_mem_fsm holds the memory FSM, wait counter and timeout. The top level keeps hazard, flush and bypass logic.

Test Plan:
- Load-use: ex_is_load=1, ex_wr_en=1, ex_dst=3, src_valid=01, src0=3 -> enable=5'b10000 for 1 cycle; bypass=0.
- ALU then mem bypass: ex_dst=2, wb_dst=2, src0=src1=2, ex_wr_en=wb_wr_en=1 -> bypass_alu=11, bypass_mem=00. Drop ex_wr_en -> bypass_mem=11.
- Indirect load: mem_req=1, mem_indirect=1; ack on cycles 3 and 6 -> mem_state 3->1->0->3; enable=0 for the 6 busy cycles.
- Timeout: store, no ack -> mem_state=2 for 15 cycles then 3; mem_timeout=1 and stays until reset.
- Taken branch: br_req for 1 cycle -> br_taken=1 next cycle only; enable=5'b10011 for 2 cycles; then all 1s.
- Async reset asserted mid-read (mem_state=0) between clock edges -> mem_state=3, enable=all 1s, mem_timeout=0 immediately.
